// File: rtl/vga_pkg.sv
// Shared 1024x768@60Hz (65 MHz pixel clock) timing constants for the video pipeline.
// Drawing stages import this package so every stage agrees on the frame geometry.
package vga_pkg;

    localparam int unsigned COUNT_W = 12;

    typedef logic [COUNT_W-1:0] count_t;

    localparam int unsigned H_VISIBLE = 1024;
    localparam int unsigned H_FRONT   = 24;
    localparam int unsigned H_SYNC    = 136;
    localparam int unsigned H_BACK    = 160;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 768;
    localparam int unsigned V_FRONT   = 3;
    localparam int unsigned V_SYNC    = 6;
    localparam int unsigned V_BACK    = 29;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Inclusive range test shared by the sync/blank decoders.
    function automatic logic in_range(input count_t value, input count_t lo, input count_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with registered sync, blank and frame-start flags.
// Flags are decoded from the next counts so they line up with the count outputs.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VIS = H_VISIBLE,
    parameter int unsigned H_FP  = H_FRONT,
    parameter int unsigned H_SW  = H_SYNC,
    parameter int unsigned H_BP  = H_BACK,
    parameter int unsigned V_VIS = V_VISIBLE,
    parameter int unsigned V_FP  = V_FRONT,
    parameter int unsigned V_SW  = V_SYNC,
    parameter int unsigned V_BP  = V_BACK
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        frame_tick
);

    localparam count_t H_LAST        = count_t'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam count_t H_BLANK_START = count_t'(H_VIS);
    localparam count_t H_SYNC_START  = count_t'(H_VIS + H_FP);
    localparam count_t H_SYNC_END    = count_t'(H_VIS + H_FP + H_SW - 1);

    localparam count_t V_LAST        = count_t'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam count_t V_BLANK_START = count_t'(V_VIS);
    localparam count_t V_SYNC_START  = count_t'(V_VIS + V_FP);
    localparam count_t V_SYNC_END    = count_t'(V_VIS + V_FP + V_SW - 1);

    logic   h_wrap;
    logic   v_wrap;
    count_t h_next;
    count_t v_next;
    logic   hsync_next;
    logic   hblnk_next;
    logic   vsync_next;
    logic   vblnk_next;
    logic   frame_next;

    // NOTE: every signal is assigned on every pass through this block, so no latch is inferred.
    always_comb begin
        // Wrap on >= rather than == so a corrupted count can only ever fall back to 0.
        h_wrap = (hcount_out >= H_LAST);
        v_wrap = (vcount_out >= V_LAST);

        h_next = h_wrap ? '0 : hcount_out + count_t'(1);
        if (!h_wrap) begin
            v_next = vcount_out;
        end else if (v_wrap) begin
            v_next = '0;
        end else begin
            v_next = vcount_out + count_t'(1);
        end

        hblnk_next = (h_next >= H_BLANK_START);
        hsync_next = in_range(h_next, H_SYNC_START, H_SYNC_END);
        vblnk_next = (v_next >= V_BLANK_START);
        vsync_next = in_range(v_next, V_SYNC_START, V_SYNC_END);
        frame_next = h_wrap && v_wrap;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hcount_out <= h_next;
            vcount_out <= v_next;
            hsync_out  <= hsync_next;
            hblnk_out  <= hblnk_next;
            vsync_out  <= vsync_next;
            vblnk_out  <= vblnk_next;
            frame_tick <= frame_next;
        end
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 clk  input  1  pixel clock, 65 MHz (1024x768 at 60 Hz); all logic on its rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on the rising edge of clk only.
REQ-003 hcount_out  output  12  horizontal pixel counter, range 0..1343.
REQ-004 hsync_out  output  1  high during the horizontal sync interval.
REQ-005 hblnk_out  output  1  high outside the horizontal visible area.
REQ-006 vcount_out  output  12  line counter, range 0..805.
REQ-007 vsync_out  output  1  high during the vertical sync interval.
REQ-008 vblnk_out  output  1  high outside the vertical visible area.
REQ-009 frame_tick  output  1  one-cycle pulse marking the first pixel of each frame.
REQ-010 All outputs SHALL be driven directly from flip-flops, with no combinational path from reset to any output.

Function
REQ-011 Horizontal timing constants SHALL be: total 1344, visible 1024, front porch 24, sync 136, back porch 160.
REQ-012 Vertical timing constants SHALL be: total 806, visible 768, front porch 3, sync 6, back porch 29.
REQ-013 hcount_out SHALL increment by 1 every cycle and wrap from 1343 to 0.
REQ-014 vcount_out SHALL increment by 1 on each cycle in which hcount_out wraps from 1343 to 0, and SHALL otherwise hold.
REQ-015 vcount_out SHALL wrap from 805 to 0 on the same edge where hcount_out wraps from 1343 to 0.
REQ-016 hblnk_out SHALL be 1 exactly when hcount_out is in 1024..1343.
REQ-017 hsync_out SHALL be 1 exactly when hcount_out is in 1048..1183.
REQ-018 vblnk_out SHALL be 1 exactly when vcount_out is in 768..805.
REQ-019 vsync_out SHALL be 1 exactly when vcount_out is in 771..776.
REQ-020 Sync and blank flags SHALL be decoded from the next-count values and registered, so each flag is cycle-aligned with the count output it describes (zero latency relative to the counts).
REQ-021 Sync polarity SHALL be active-high at this block; any inversion to the monitor's negative polarity is done at top level.
REQ-022 frame_tick SHALL be 1 only in the cycle in which (vcount_out, hcount_out) = (0, 0) following a wrap from (805, 1343).
REQ-023 frame_tick SHALL NOT assert on the cycle immediately following reset release.
REQ-024 Counter arithmetic SHALL be 12-bit unsigned.
REQ-025 Counters SHALL never hold a value outside their range; the block has no illegal state reachable from reset.
REQ-026 Downstream pipeline stages consume the six timing outputs unchanged; this block SHALL produce them in the same port order and widths those stages accept.

Reset
REQ-027 While reset is high, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out and frame_tick SHALL all be 0.
REQ-028 On the first rising edge with reset low, hcount_out SHALL become 1 and vcount_out SHALL stay 0.
REQ-029 Reset asserted mid-frame SHALL return all outputs to 0 on that edge; the frame restarts from (0, 0) with no frame_tick until the next full wrap.

Structure
REQ-030 Timing constants (H/V total, visible, front porch, sync, back porch) and count width SHALL live in a shared package, vga_pkg, reused by all drawing stages.
REQ-031 The block SHALL be a single module with no sub-module; the two counters and the registered decode are implemented inline.

Verification
REQ-032 Scenario: reset for 5 cycles, then release -> all outputs 0 during reset; hcount_out = 1, vcount_out = 0 after the first edge; frame_tick stays 0.
REQ-033 Scenario: run one line -> hblnk_out rises with hcount_out = 1024; hsync_out is high for hcount_out 1048..1183 (136 cycles); hcount_out wraps 1343 -> 0 and vcount_out increments 0 -> 1.
REQ-034 Scenario: run one full frame (1344 x 806 = 1,083,264 cycles) -> vblnk_out is high for vcount_out 768..805; vsync_out is high for 6 lines (771..776); frame_tick is high exactly once, at (0, 0).
REQ-035 Scenario: run three frames -> frame_tick period is exactly 1,083,264 cycles; counters never exceed 1343 / 805.
REQ-036 Scenario: assert reset at vcount_out = 400, hcount_out = 700 for 1 cycle -> all outputs are 0 on the next edge, counting resumes from 1, and the next frame_tick arrives 1,083,264 cycles after reset release.
REQ-037 Scenario: continuous checker -> every cycle, hblnk_out, hsync_out, vblnk_out and vsync_out match their range decodes of the same-cycle hcount_out and vcount_out.
